count_driver: RTL

Stimulus sequencer for the dual-channel event counter: it accepts a command holding a channel-0 increment count and a channel-1 increment count, then drives the counter's `Slt`/`En` inputs with exactly the pulse train that produces those increments. Channel 1 behind the counter has a divide-by-4 prescaler, so the driver issues four `Slt=1` pulses per requested channel-1 increment. It sits between the test/control logic and the counter, and reports completion with a `Busy`/`Done` handshake.

---
 rtl/count_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/count_driver.sv
// Stimulus sequencer for the dual-channel event counter: turns a (Num0, Num1) command into Slt/En pulses.
// Optional expected-total mirror outputs Exp0/Exp1 are built when CNT_DRIVE_MIRROR_EN is defined.
module count_driver #(
  parameter int W   = 16,
  parameter int GAP = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] Num0,
  input  logic [W-1:0] Num1,
  output logic         Slt,
  output logic         En,
  output logic         Busy,
  output logic         Done
`ifdef CNT_DRIVE_MIRROR_EN
  ,
  output logic [63:0]  Exp0,
  output logic [63:0]  Exp1
`endif
);

  localparam int PW = W + 2;
  localparam logic [3:0] GAP_Q = 4'(GAP);

  typedef enum logic [1:0] {IDLE, RUN0, RUN1, FIN} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [3:0]    gcnt, gcnt_n;
  logic          in_gap, in_gap_n;
  logic [W-1:0]  num1_q, num1_n;
  logic          unit_end;
  logic          slt_n, en_n, busy_n, done_n;

  // Channel 1 pulses come in whole groups of four so the downstream prescaler never sees a partial group.
  function automatic logic [PW-1:0] ch1_pulses_m1(input logic [W-1:0] n);
    return {n, 2'b00} - PW'(1);
  endfunction

  function automatic logic [PW-1:0] ch0_pulses_m1(input logic [W-1:0] n);
    return {2'b00, n} - PW'(1);
  endfunction

  // pcnt holds pulses still to issue after the current one; gcnt counts down idle cycles of a gap.
  always_comb begin
    state_n  = state;
    pcnt_n   = pcnt;
    gcnt_n   = gcnt;
    in_gap_n = in_gap;
    num1_n   = num1_q;
    unit_end = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          num1_n   = Num1;
          in_gap_n = 1'b0;
          gcnt_n   = 4'd0;
          if (Num0 != '0) begin
            state_n = RUN0;
            pcnt_n  = ch0_pulses_m1(Num0);
          end else if (Num1 != '0) begin
            state_n = RUN1;
            pcnt_n  = ch1_pulses_m1(Num1);
          end else begin
            state_n = FIN;
          end
        end
      end
      RUN0, RUN1: begin
        if (!in_gap) begin
          if (GAP_Q != 4'd0) begin
            in_gap_n = 1'b1;
            gcnt_n   = GAP_Q;
          end else begin
            unit_end = 1'b1;
          end
        end else if (gcnt > 4'd1) begin
          gcnt_n = gcnt - 4'd1;
        end else begin
          unit_end = 1'b1;
        end
        if (unit_end) begin
          in_gap_n = 1'b0;
          gcnt_n   = 4'd0;
          if (pcnt != '0) begin
            pcnt_n = pcnt - PW'(1);
          end else if (state == RUN0 && num1_q != '0) begin
            state_n = RUN1;
            pcnt_n  = ch1_pulses_m1(num1_q);
          end else begin
            state_n = FIN;
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    en_n   = (state_n == RUN0 || state_n == RUN1) && !in_gap_n;
    slt_n  = (state_n == RUN1);
    busy_n = (state_n != IDLE);
    done_n = (state_n == FIN);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      pcnt   <= '0;
      gcnt   <= 4'd0;
      in_gap <= 1'b0;
      num1_q <= '0;
      Slt    <= 1'b0;
      En     <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      state  <= state_n;
      pcnt   <= pcnt_n;
      gcnt   <= gcnt_n;
      in_gap <= in_gap_n;
      num1_q <= num1_n;
      Slt    <= slt_n;
      En     <= en_n;
      Busy   <= busy_n;
      Done   <= done_n;
    end
  end

`ifdef CNT_DRIVE_MIRROR_EN
  logic [1:0] ph1;

  // ph1 tracks the position inside the current group of four channel-1 pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Exp0 <= 64'd0;
      Exp1 <= 64'd0;
      ph1  <= 2'd0;
    end else begin
      if (state == IDLE && Start) begin
        ph1 <= 2'd0;
      end else if (En && Slt) begin
        ph1 <= ph1 + 2'd1;
        if (ph1 == 2'd3) Exp1 <= Exp1 + 64'd1;
      end
      if (En && !Slt) Exp0 <= Exp0 + 64'd1;
    end
  end
`endif

endmodule
